axi4_lite_slave_read_protocol_checker: RTL and testbench
========================================================

Name: axi4_lite_slave_read_protocol_checker

Overview:
- Synthesizable, parametrised protocol checker for the AXI4-Lite slave read path (AR and R channels). It is passive and sits beside the slave-read BFM or the DUT port.
- Monitors stability, ready/valid wait bounds, AR-to-R latency, outstanding depth and illegal responses.
- Reports per-cycle error pulses, sticky errors and the first error seen.
- It is the parametrised successor to the fixed-constant read assert/cover set: multi-outstanding tracking and runtime reporting are new.

Parameters:
- ADDR_WIDTH, 32, araddr width.
- DATA_WIDTH, 32, rdata width (32 or 64).
- MAX_OUTSTANDING, 4, depth of the AR timestamp FIFO, >=1.
- MAX_DELAY_READY, 16, maximum cycles arvalid may wait for arready.
- MAX_DELAY_VALID, 16, maximum cycles rvalid may wait for rready.
- MAX_DELAY_RVALID, 10, maximum cycles from AR handshake to first rvalid of that request.
- CNT_WIDTH, 8, width of the timestamp and wait counters. Must satisfy 2**CNT_WIDTH > 2*max(all delays).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- arvalid, arready  in  1  AR handshake.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  protection.
- rvalid, rready  in  1  R handshake.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  2  read response.
- err_clear  in  1  clears sticky and first-error state.
- err_pulse  out  8  per-bit error detected this cycle.
- err_sticky  out  8  accumulated errors.
- err_any  out  1  OR of err_sticky.
- first_err_valid  out  1  first_err_code is meaningful.
- first_err_code  out  3  index of first error.
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  accepted AR not yet answered by an R handshake.

Behaviour:
- Reset: all outputs 0; counters 0; FIFO empty. Reset mid-transaction discards all tracking; no errors are flagged in the reset cycle or the cycle after.
- All checks are sampled at the aclk edge. err_pulse is registered, so there is one cycle of latency from the offending sample.
- Error bit map:
  - 0 AR_UNSTABLE: arvalid dropped, or araddr/arprot changed, while arvalid=1 and arready=0 in the previous cycle.
  - 1 AR_READY_TIMEOUT: AR wait counter reaches MAX_DELAY_READY+1. Fires once per pending AR.
  - 2 R_UNSTABLE: same rule as bit 0 applied to rvalid/rdata/rresp.
  - 3 R_READY_TIMEOUT: R wait counter exceeds MAX_DELAY_VALID. Fires once.
  - 4 RVALID_LATENCY: FIFO non-empty, rvalid=0 and (now - head timestamp) mod 2**CNT_WIDTH > MAX_DELAY_RVALID. Fires once per head entry, using a per-head flag that clears on pop.
  - 5 R_WITHOUT_AR: rvalid=1 while outstanding_cnt=0. A same-cycle AR handshake does not excuse it.
  - 6 OUTSTANDING_OVERFLOW: AR handshake when count=MAX_OUTSTANDING and no R handshake in the same cycle. The push is dropped and the count saturates.
  - 7 RRESP_EXOKAY: R handshake with rresp=2'b01.
- Wait counters: increment while valid=1 and ready=0; clear on handshake or when valid drops. They saturate at all-ones.
- Timestamp FIFO:
  - A free-running CNT_WIDTH counter wraps naturally.
  - AR handshake pushes the current timestamp; R handshake pops the head.
  - Simultaneous push and pop: count unchanged and both operations happen. This also applies at full, with no overflow flagged.
  - A pop when empty is already covered by bit 5 and leaves the count at 0.
- Sticky and first error:
  - err_sticky |= err_pulse.
  - first_err_code latches the lowest set bit of the first non-zero err_pulse while first_err_valid=0, and sets first_err_valid.
  - err_clear has priority over same-cycle new errors: state clears, and that cycle's pulses are not captured. err_pulse itself is never masked.

Optional Feature:
- Macro: AXI4LITE_SLAVE_READ_CHECKER_COVER_EN.
- Defined: adds outputs cov_ar_cnt (32), cov_r_cnt (32), cov_b2b_cnt (32) and cov_max_latency (CNT_WIDTH).
  - cov_b2b_cnt counts R handshakes in consecutive cycles.
  - cov_max_latency is the running maximum AR-to-rvalid age.
  - All reset to 0, saturate, and are cleared by err_clear.
- Undefined: these ports and registers do not exist; checking behaviour is identical.

Decomposition:
- Package axi4_lite_slave_read_checker_pkg holds:
  - default delay constants;
  - the error-index enum (AR_UNSTABLE..RRESP_EXOKAY);
  - the RESP_OKAY/EXOKAY/SLVERR/DECERR localparams;
  - the NUM_ERR=8 constant.
- Sub-module axi4_lite_checker_ts_fifo: parametrised depth and width, push/pop/full/empty/head.

Test Plan:
- AR with arready delayed 16 cycles -> no error. Delayed 17 -> err_pulse[1] once, first_err_code=1.
- araddr changes 0x100->0x104 while arvalid=1, arready=0 -> err_pulse[0]; err_sticky[0] stays set until err_clear.
- 4 back-to-back ARs, rvalid 10 cycles after each -> clean, outstanding_cnt peaks at 4. Fifth AR with no R -> err_pulse[6]; then delay rvalid 11 cycles -> err_pulse[4].
- rvalid asserted with 0 outstanding -> err_pulse[5]. R handshake with rresp=01 -> err_pulse[7].
- Full FIFO with simultaneous AR and R handshake -> no error, count stays 4.
- areset mid-burst, then a clean transaction -> outputs 0 and no spurious errors. With COVER_EN, cov_ar_cnt equals post-reset ARs only.

Source files
------------

// File: rtl/axi4_lite_slave_read_checker_pkg.sv
// ============================================================================
// Module  : axi4_lite_slave_read_checker_pkg
// Brief   : Shared constants, error indices and helpers for the AXI4-Lite
//           slave read protocol checker.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package axi4_lite_slave_read_checker_pkg;

    localparam int DEF_MAX_DELAY_READY  = 16;
    localparam int DEF_MAX_DELAY_VALID  = 16;
    localparam int DEF_MAX_DELAY_RVALID = 10;
    localparam int NUM_ERR              = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ERR_AR_UNSTABLE          = 3'd0,
        ERR_AR_READY_TIMEOUT     = 3'd1,
        ERR_R_UNSTABLE           = 3'd2,
        ERR_R_READY_TIMEOUT      = 3'd3,
        ERR_RVALID_LATENCY       = 3'd4,
        ERR_R_WITHOUT_AR         = 3'd5,
        ERR_OUTSTANDING_OVERFLOW = 3'd6,
        ERR_RRESP_EXOKAY         = 3'd7
    } err_idx_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [NUM_ERR-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_checker_ts_fifo.sv
// ============================================================================
// Module  : axi4_lite_checker_ts_fifo
// Brief   : Small FIFO holding AR-acceptance timestamps; supports push and pop
//           in the same cycle even when full.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi4_lite_checker_ts_fifo #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 8,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WIDTH-1:0]   i_din,
    output logic [WIDTH-1:0]   o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == COUNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_slave_read_protocol_checker.sv
// ============================================================================
// Module  : axi4_lite_slave_read_protocol_checker
// Brief   : Passive AXI4-Lite slave read-path checker with error pulses,
//           sticky/first-error reporting. Optional coverage counters are
//           enabled by AXI4LITE_SLAVE_READ_CHECKER_COVER_EN.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi4_lite_slave_read_protocol_checker
    import axi4_lite_slave_read_checker_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int MAX_DELAY_READY  = DEF_MAX_DELAY_READY,
    parameter int MAX_DELAY_VALID  = DEF_MAX_DELAY_VALID,
    parameter int MAX_DELAY_RVALID = DEF_MAX_DELAY_RVALID,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   arvalid,
    input  logic                                   arready,
    input  logic [ADDR_WIDTH-1:0]                  araddr,
    input  logic [2:0]                             arprot,
    input  logic                                   rvalid,
    input  logic                                   rready,
    input  logic [DATA_WIDTH-1:0]                  rdata,
    input  logic [1:0]                             rresp,
    input  logic                                   err_clear,
    output logic [NUM_ERR-1:0]                     err_pulse,
    output logic [NUM_ERR-1:0]                     err_sticky,
    output logic                                   err_any,
    output logic                                   first_err_valid,
    output logic [2:0]                             first_err_code,
`ifdef AXI4LITE_SLAVE_READ_CHECKER_COVER_EN
    output logic [31:0]                            cov_ar_cnt,
    output logic [31:0]                            cov_r_cnt,
    output logic [31:0]                            cov_b2b_cnt,
    output logic [CNT_WIDTH-1:0]                   cov_max_latency,
`endif
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_WIDTH-1:0]  w_head;
    logic [CNT_WIDTH-1:0]  w_age;
    logic [OCW-1:0]        w_fifo_cnt;
    logic [NUM_ERR-1:0]    w_err;

    logic [CNT_WIDTH-1:0]  r_ts;
    logic [CNT_WIDTH-1:0]  r_ar_wait;
    logic [CNT_WIDTH-1:0]  r_r_wait;
    logic                  r_prev_arvalid;
    logic                  r_prev_arready;
    logic [ADDR_WIDTH-1:0] r_prev_araddr;
    logic [2:0]            r_prev_arprot;
    logic                  r_prev_rvalid;
    logic                  r_prev_rready;
    logic [DATA_WIDTH-1:0] r_prev_rdata;
    logic [1:0]            r_prev_rresp;
    logic                  r_armed;
    logic                  r_lat_flag;

    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rvalid && rready;
    assign w_age   = r_ts - w_head;

    axi4_lite_checker_ts_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .WIDTH   (CNT_WIDTH),
        .COUNT_W (OCW)
    ) u_ts_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_ar_hs),
        .i_pop   (w_r_hs),
        .i_din   (r_ts),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    assign outstanding_cnt = w_fifo_cnt;
    assign err_any         = |err_sticky;

    always_comb begin
        w_err = '0;
        w_err[ERR_AR_UNSTABLE] = r_prev_arvalid && !r_prev_arready &&
            (!arvalid || (araddr != r_prev_araddr) || (arprot != r_prev_arprot));
        w_err[ERR_AR_READY_TIMEOUT] = arvalid && !arready &&
            (r_ar_wait == CNT_WIDTH'(MAX_DELAY_READY));
        w_err[ERR_R_UNSTABLE] = r_prev_rvalid && !r_prev_rready &&
            (!rvalid || (rdata != r_prev_rdata) || (rresp != r_prev_rresp));
        w_err[ERR_R_READY_TIMEOUT] = rvalid && !rready &&
            (r_r_wait == CNT_WIDTH'(MAX_DELAY_VALID));
        w_err[ERR_RVALID_LATENCY] = !w_empty && !rvalid && !r_lat_flag &&
            (w_age > CNT_WIDTH'(MAX_DELAY_RVALID));
        w_err[ERR_R_WITHOUT_AR]         = rvalid && w_empty;
        w_err[ERR_OUTSTANDING_OVERFLOW] = w_ar_hs && w_full && !w_r_hs;
        w_err[ERR_RRESP_EXOKAY]         = w_r_hs && (rresp == RESP_EXOKAY);
        // History registers are meaningless in the first sample after reset.
        if (!r_armed) w_err = '0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ts            <= '0;
            r_ar_wait       <= '0;
            r_r_wait        <= '0;
            r_prev_arvalid  <= 1'b0;
            r_prev_arready  <= 1'b0;
            r_prev_araddr   <= '0;
            r_prev_arprot   <= '0;
            r_prev_rvalid   <= 1'b0;
            r_prev_rready   <= 1'b0;
            r_prev_rdata    <= '0;
            r_prev_rresp    <= '0;
            r_armed         <= 1'b0;
            r_lat_flag      <= 1'b0;
            err_pulse       <= '0;
            err_sticky      <= '0;
            first_err_valid <= 1'b0;
            first_err_code  <= '0;
        end else begin
            r_ts           <= r_ts + 1'b1;
            r_prev_arvalid <= arvalid;
            r_prev_arready <= arready;
            r_prev_araddr  <= araddr;
            r_prev_arprot  <= arprot;
            r_prev_rvalid  <= rvalid;
            r_prev_rready  <= rready;
            r_prev_rdata   <= rdata;
            r_prev_rresp   <= rresp;
            r_armed        <= 1'b1;
            err_pulse      <= w_err;

            if (arvalid && !arready) begin
                if (r_ar_wait != '1) r_ar_wait <= r_ar_wait + 1'b1;
            end else begin
                r_ar_wait <= '0;
            end
            if (rvalid && !rready) begin
                if (r_r_wait != '1) r_r_wait <= r_r_wait + 1'b1;
            end else begin
                r_r_wait <= '0;
            end

            if (w_r_hs && !w_empty)              r_lat_flag <= 1'b0;
            else if (w_err[ERR_RVALID_LATENCY])  r_lat_flag <= 1'b1;

            if (err_clear) begin
                err_sticky      <= '0;
                first_err_valid <= 1'b0;
                first_err_code  <= '0;
            end else begin
                err_sticky <= err_sticky | w_err;
                if (!first_err_valid && (|w_err)) begin
                    first_err_valid <= 1'b1;
                    first_err_code  <= lowest_set(w_err);
                end
            end
        end
    end

`ifdef AXI4LITE_SLAVE_READ_CHECKER_COVER_EN
    logic                 r_prev_r_hs;
    logic [31:0]          r_cov_ar_cnt;
    logic [31:0]          r_cov_r_cnt;
    logic [31:0]          r_cov_b2b_cnt;
    logic [CNT_WIDTH-1:0] r_cov_max_lat;

    assign cov_ar_cnt      = r_cov_ar_cnt;
    assign cov_r_cnt       = r_cov_r_cnt;
    assign cov_b2b_cnt     = r_cov_b2b_cnt;
    assign cov_max_latency = r_cov_max_lat;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_prev_r_hs   <= 1'b0;
            r_cov_ar_cnt  <= '0;
            r_cov_r_cnt   <= '0;
            r_cov_b2b_cnt <= '0;
            r_cov_max_lat <= '0;
        end else begin
            r_prev_r_hs <= w_r_hs;
            if (err_clear) begin
                r_cov_ar_cnt  <= '0;
                r_cov_r_cnt   <= '0;
                r_cov_b2b_cnt <= '0;
                r_cov_max_lat <= '0;
            end else begin
                if (w_ar_hs && (r_cov_ar_cnt != '1))                r_cov_ar_cnt  <= r_cov_ar_cnt + 1'b1;
                if (w_r_hs && (r_cov_r_cnt != '1))                  r_cov_r_cnt   <= r_cov_r_cnt + 1'b1;
                if (w_r_hs && r_prev_r_hs && (r_cov_b2b_cnt != '1)) r_cov_b2b_cnt <= r_cov_b2b_cnt + 1'b1;
                if (rvalid && !w_empty && (w_age > r_cov_max_lat))  r_cov_max_lat <= w_age;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slave_read_protocol_checker.sv
// ============================================================================
// Module  : tb_axi4_lite_slave_read_protocol_checker
// Brief   : Directed self-checking bench for the AXI4-Lite read checker.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_lite_slave_read_protocol_checker;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arvalid, arready, rvalid, rready, err_clear;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [7:0]  err_pulse, err_sticky;
    logic        err_any, first_err_valid;
    logic [2:0]  first_err_code;
    logic [2:0]  outstanding_cnt;
`ifdef AXI4LITE_SLAVE_READ_CHECKER_COVER_EN
    logic [31:0] cov_ar_cnt, cov_r_cnt, cov_b2b_cnt;
    logic [7:0]  cov_max_latency;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 aclk = ~aclk;

    axi4_lite_slave_read_protocol_checker dut (
        .aclk            (aclk),
        .areset          (areset),
        .arvalid         (arvalid),
        .arready         (arready),
        .araddr          (araddr),
        .arprot          (arprot),
        .rvalid          (rvalid),
        .rready          (rready),
        .rdata           (rdata),
        .rresp           (rresp),
        .err_clear       (err_clear),
        .err_pulse       (err_pulse),
        .err_sticky      (err_sticky),
        .err_any         (err_any),
        .first_err_valid (first_err_valid),
        .first_err_code  (first_err_code),
`ifdef AXI4LITE_SLAVE_READ_CHECKER_COVER_EN
        .cov_ar_cnt      (cov_ar_cnt),
        .cov_r_cnt       (cov_r_cnt),
        .cov_b2b_cnt     (cov_b2b_cnt),
        .cov_max_latency (cov_max_latency),
`endif
        .outstanding_cnt (outstanding_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: queue the pulse expected from this sample, then compare it.
    task automatic cyc(input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        @(posedge aclk);
        #1;
        e = exp_q.pop_front();
        check("err_pulse", {24'd0, err_pulse}, {24'd0, e});
    endtask

    task automatic idle();
        arvalid = 0; arready = 0; araddr = 0; arprot = 0;
        rvalid = 0; rready = 0; rdata = 0; rresp = 0; err_clear = 0;
    endtask

    task automatic ar(input logic [31:0] addr, input logic [7:0] exp);
        arvalid = 1; arready = 1; araddr = addr;
        cyc(exp);
        arvalid = 0; arready = 0;
    endtask

    task automatic rd(input logic [1:0] resp, input logic [7:0] exp);
        rvalid = 1; rready = 1; rresp = resp;
        cyc(exp);
        rvalid = 0; rready = 0; rresp = 0;
    endtask

    task automatic clr();
        err_clear = 1;
        cyc(0);
        err_clear = 0;
        check("sticky_after_clear", {24'd0, err_sticky}, 0);
        check("first_valid_after_clear", {31'd0, first_err_valid}, 0);
    endtask

    initial begin
        idle();
        areset = 1;
        #1;
        cyc(0); cyc(0);
        check("rst_sticky", {24'd0, err_sticky}, 0);
        check("rst_any", {31'd0, err_any}, 0);
        check("rst_first_valid", {31'd0, first_err_valid}, 0);
        check("rst_first_code", {29'd0, first_err_code}, 0);
        check("rst_outstanding", {29'd0, outstanding_cnt}, 0);
        areset = 0;
        cyc(0); cyc(0);

        // arready after 16 waiting cycles: legal
        arvalid = 1; araddr = 32'h10;
        repeat (16) cyc(0);
        arready = 1; cyc(0);
        arvalid = 0; arready = 0;
        check("ar16_cnt", {29'd0, outstanding_cnt}, 1);
        rd(0, 0);
        check("ar16_cnt_after_r", {29'd0, outstanding_cnt}, 0);
        check("ar16_sticky", {24'd0, err_sticky}, 0);

        // arready after 17 waiting cycles: single timeout pulse
        arvalid = 1; araddr = 32'h20;
        repeat (16) cyc(0);
        cyc(8'h02);
        arready = 1; cyc(0);
        arvalid = 0; arready = 0;
        rd(0, 0);
        check("ar17_sticky", {24'd0, err_sticky}, 32'h02);
        check("ar17_any", {31'd0, err_any}, 1);
        check("ar17_first_valid", {31'd0, first_err_valid}, 1);
        check("ar17_first_code", {29'd0, first_err_code}, 1);
        clr();

        // araddr changes while waiting
        arvalid = 1; arready = 0; araddr = 32'h100;
        cyc(0);
        araddr = 32'h104;
        cyc(8'h01);
        ar(32'h104, 0);
        rd(0, 0);
        repeat (3) cyc(0);
        check("unstable_sticky_held", {24'd0, err_sticky}, 32'h01);
        check("unstable_code", {29'd0, first_err_code}, 0);
        clr();

        // four back-to-back ARs, each answered 10 cycles later
        for (int i = 0; i < 4; i++) ar(32'h200 + 32'(4 * i), 0);
        check("b2b_peak", {29'd0, outstanding_cnt}, 4);
        repeat (7) cyc(0);
        for (int i = 0; i < 4; i++) rd(0, 0);
        check("b2b_drain", {29'd0, outstanding_cnt}, 0);
        check("b2b_sticky", {24'd0, err_sticky}, 0);

        // overflow, then rvalid late by one cycle beyond the bound
        for (int i = 0; i < 4; i++) ar(32'h300, 0);
        ar(32'h310, 8'h40);
        check("ovf_cnt_saturates", {29'd0, outstanding_cnt}, 4);
        repeat (6) cyc(0);
        cyc(8'h10);
        cyc(0);
        for (int i = 0; i < 4; i++) rd(0, 0);
        check("ovf_drain", {29'd0, outstanding_cnt}, 0);
        check("ovf_sticky", {24'd0, err_sticky}, 32'h50);
        check("ovf_first_code", {29'd0, first_err_code}, 6);
        clr();

        // full FIFO with simultaneous AR and R handshakes
        for (int i = 0; i < 4; i++) ar(32'h400, 0);
        arvalid = 1; arready = 1; rvalid = 1; rready = 1;
        cyc(0);
        idle();
        check("full_swap_cnt", {29'd0, outstanding_cnt}, 4);
        for (int i = 0; i < 4; i++) rd(0, 0);
        check("full_swap_drain", {29'd0, outstanding_cnt}, 0);
        check("full_swap_sticky", {24'd0, err_sticky}, 0);

        // R with nothing outstanding, also with a same-cycle AR
        rd(0, 8'h20);
        check("r_wo_ar_cnt", {29'd0, outstanding_cnt}, 0);
        check("r_wo_ar_code", {29'd0, first_err_code}, 5);
        clr();
        arvalid = 1; arready = 1; rvalid = 1; rready = 1;
        cyc(8'h20);
        idle();
        check("r_wo_ar_same_ar_cnt", {29'd0, outstanding_cnt}, 1);
        rd(0, 0);
        clr();

        // EXOKAY response
        ar(32'h500, 0);
        rd(2'b01, 8'h80);
        check("exokay_sticky", {24'd0, err_sticky}, 32'h80);
        check("exokay_code", {29'd0, first_err_code}, 7);
        clr();
        rd(2'b01, 8'hA0);
        check("two_errs_code", {29'd0, first_err_code}, 5);
        clr();

        // err_clear wins over a same-cycle error, pulse still visible
        err_clear = 1; rvalid = 1; rready = 1;
        cyc(8'h20);
        idle();
        check("clr_prio_sticky", {24'd0, err_sticky}, 0);
        check("clr_prio_first_valid", {31'd0, first_err_valid}, 0);

        // rready withheld 17 cycles
        ar(32'h600, 0);
        rvalid = 1; rready = 0; rdata = 32'hAA;
        repeat (16) cyc(0);
        cyc(8'h08);
        rready = 1; cyc(0);
        idle();
        check("rto_sticky", {24'd0, err_sticky}, 32'h08);
        check("rto_cnt", {29'd0, outstanding_cnt}, 0);
        clr();

        // rdata change and rvalid drop while waiting
        ar(32'h700, 0);
        rvalid = 1; rready = 0; rdata = 32'h11;
        cyc(0);
        rdata = 32'h22;
        cyc(8'h04);
        rready = 1; cyc(0);
        idle();
        ar(32'h704, 0);
        rvalid = 1; rready = 0;
        cyc(0);
        rvalid = 0;
        cyc(8'h04);
        rd(0, 0);
        check("r_unstable_sticky", {24'd0, err_sticky}, 32'h04);
        clr();

        // reset in the middle of a burst, then one clean transaction
        for (int i = 0; i < 4; i++) ar(32'h800, 0);
        ar(32'h810, 8'h40);
        arvalid = 1; arready = 0; araddr = 32'h820; rvalid = 1;
        cyc(0);
        areset = 1;
        cyc(0);
        check("mid_rst_sticky", {24'd0, err_sticky}, 0);
        check("mid_rst_any", {31'd0, err_any}, 0);
        check("mid_rst_first_valid", {31'd0, first_err_valid}, 0);
        check("mid_rst_cnt", {29'd0, outstanding_cnt}, 0);
        areset = 0;
        idle();
        cyc(0); cyc(0);
        ar(32'h900, 0);
        check("post_rst_cnt", {29'd0, outstanding_cnt}, 1);
        rd(0, 0);
        cyc(0);
        check("post_rst_drain", {29'd0, outstanding_cnt}, 0);
        check("post_rst_sticky", {24'd0, err_sticky}, 0);
`ifdef AXI4LITE_SLAVE_READ_CHECKER_COVER_EN
        check("cov_ar_cnt", cov_ar_cnt, 1);
        check("cov_r_cnt", cov_r_cnt, 1);
        check("cov_b2b_cnt", cov_b2b_cnt, 0);
        check("cov_max_latency", {24'd0, cov_max_latency}, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
